// File: rtl/store_lane_buffer_if.sv
// Store request and memory write-port handshakes of the store lane buffer.
// master drives requests and consumes memory writes; slave is the buffer itself.
interface store_lane_buffer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic [DATA_W-1:0] req_data;

  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [BE_W-1:0]   mem_be;
  logic [DATA_W-1:0] mem_wdata;

  modport master (
    output req_valid, req_addr, req_size, req_data, mem_ready,
    input  req_ready, mem_valid, mem_addr, mem_be, mem_wdata
  );

  modport slave (
    input  req_valid, req_addr, req_size, req_data, mem_ready,
    output req_ready, mem_valid, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/store_lane_buffer.sv
// Store path: alignment check, byte-lane steering and a DEPTH-entry FIFO to memory.
// Entries appear on mem_* one cycle after acceptance; req_ready drops only when full.
module store_lane_buffer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  store_lane_buffer_if.slave     bus,
  output logic                   exc_ades,
  output logic [ADDR_W-1:0]      exc_addr,
  output logic [$clog2(DEPTH):0] count
);
  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [OFF_W-1:0]  off;
  logic [3:0]        nbytes;
  logic              legal;
  logic [BE_W-1:0]   be_base;
  logic [BE_W-1:0]   be_new;
  logic [DATA_W-1:0] data_masked;
  logic [DATA_W-1:0] wdata_new;
  logic [ADDR_W-1:0] addr_new;
  logic              accept;
  logic              push;
  logic              pop;
  logic              reject;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  logic [ADDR_W-1:0] addr_mem  [DEPTH];
  logic [BE_W-1:0]   be_mem    [DEPTH];
  logic [DATA_W-1:0] wdata_mem [DEPTH];

  always_comb begin
    off    = bus.req_addr[OFF_W-1:0];
    nbytes = 4'd1 << bus.req_size;
    // size must fit the bus and the offset must be a multiple of the size
    legal  = (bus.req_size <= 2'(OFF_W)) &&
             ((off & OFF_W'(nbytes - 4'd1)) == '0);
    for (int i = 0; i < BE_W; i++) begin
      be_base[i]           = (4'(i) < nbytes);
      data_masked[8*i +: 8] = (4'(i) < nbytes) ? bus.req_data[8*i +: 8] : 8'h00;
    end
    be_new    = be_base << off;
    wdata_new = data_masked << {off, 3'b000};
    addr_new  = {bus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  end

  assign bus.req_ready = (count != CNT_W'(DEPTH));
  assign bus.mem_valid = (count != '0);
  assign accept        = bus.req_valid & bus.req_ready;
  assign push          = accept & legal;
  assign reject        = accept & ~legal;
  assign pop           = bus.mem_valid & bus.mem_ready;

  // Gating on mem_valid keeps the port at zero when empty and after reset.
  assign bus.mem_addr  = bus.mem_valid ? addr_mem[rd_ptr]  : '0;
  assign bus.mem_be    = bus.mem_valid ? be_mem[rd_ptr]    : '0;
  assign bus.mem_wdata = bus.mem_valid ? wdata_mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      exc_ades <= 1'b0;
      exc_addr <= '0;
    end else begin
      exc_ades <= reject;
      if (reject) exc_addr <= bus.req_addr;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // Storage needs no reset: nothing is visible unless count says so.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr]  <= addr_new;
      be_mem[wr_ptr]    <= be_new;
      wdata_mem[wr_ptr] <= wdata_new;
    end
  end
endmodule

// File: tb/tb_store_lane_buffer.sv
// Bench for store_lane_buffer: 32-bit/DEPTH 4 and 64-bit/DEPTH 2 instances against a queue model.
module tb_store_lane_buffer;
  logic clk = 1'b0;
  logic reset_n;
  logic flush;
  always #5 clk = ~clk;

  store_lane_buffer_if #(.DATA_W(32), .ADDR_W(32)) b32();
  store_lane_buffer_if #(.DATA_W(64), .ADDR_W(32)) b64();

  logic        e32_v, e64_v;
  logic [31:0] e32_a, e64_a;
  logic [2:0]  c32;
  logic [1:0]  c64;

  store_lane_buffer #(.DATA_W(32), .ADDR_W(32), .DEPTH(4)) u32 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .bus(b32.slave),
    .exc_ades(e32_v), .exc_addr(e32_a), .count(c32));
  store_lane_buffer #(.DATA_W(64), .ADDR_W(32), .DEPTH(2)) u64 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .bus(b64.slave),
    .exc_ades(e64_v), .exc_addr(e64_a), .count(c64));

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  be;
    logic [63:0] wd;
  } ent_t;

  typedef struct {
    bit          v;
    logic [31:0] a;
    logic [1:0]  s;
    logic [63:0] d;
    bit          mr;
  } stim_t;

  ent_t        q32[$];
  ent_t        q64[$];
  bit          xv[2];
  logic [31:0] xa[2];
  stim_t       st[2];
  bit          fl;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit legal_of(int bew, logic [31:0] a, logic [1:0] s);
    int nb  = 1 << s;
    int off = int'(a % 32'(bew));
    return (nb <= bew) && (off % nb == 0);
  endfunction

  function automatic ent_t entry_of(int bew, logic [31:0] a, logic [1:0] s, logic [63:0] d);
    ent_t        e;
    int          nb  = 1 << s;
    int          off = int'(a % 32'(bew));
    logic [63:0] m;
    m      = (nb == 8) ? d : (d & ((64'd1 << (nb * 8)) - 64'd1));
    e.addr = a - 32'(off);
    e.be   = 8'(((1 << nb) - 1) << off);
    e.wd   = m << (off * 8);
    return e;
  endfunction

  task automatic drive();
    b32.req_valid = st[0].v;
    b32.req_addr  = st[0].a;
    b32.req_size  = st[0].s;
    b32.req_data  = st[0].d[31:0];
    b32.mem_ready = st[0].mr;
    b64.req_valid = st[1].v;
    b64.req_addr  = st[1].a;
    b64.req_size  = st[1].s;
    b64.req_data  = st[1].d;
    b64.mem_ready = st[1].mr;
    flush         = fl;
  endtask

  // Predict the state after the coming clock edge from the staged inputs.
  task automatic upd(int k, int bew, int depth);
    ent_t q[$];
    bit   acc, lg, pop;
    if (k == 0) q = q32; else q = q64;
    acc   = st[k].v && (q.size() != depth);
    lg    = legal_of(bew, st[k].a, st[k].s);
    pop   = (q.size() != 0) && st[k].mr;
    xv[k] = acc && !lg;
    if (acc && !lg) xa[k] = st[k].a;
    if (fl) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (acc && lg) q.push_back(entry_of(bew, st[k].a, st[k].s, st[k].d));
    end
    if (k == 0) q32 = q; else q64 = q;
  endtask

  task automatic cmp_one(string t, int n, int depth, ent_t h, logic [63:0] cnt,
                         logic rdy, logic vld, logic [63:0] ad, logic [63:0] be,
                         logic [63:0] wd, logic ev, logic [63:0] ea, int k);
    chk({t, "count"}, cnt, 64'(n));
    chk({t, "req_ready"}, rdy, 64'(n != depth));
    chk({t, "mem_valid"}, vld, 64'(n != 0));
    chk({t, "mem_be"}, be, (n != 0) ? 64'(h.be) : 64'd0);
    if (n != 0) begin
      chk({t, "mem_addr"}, ad, 64'(h.addr));
      chk({t, "mem_wdata"}, wd, h.wd);
    end
    chk({t, "exc_ades"}, ev, 64'(xv[k]));
    chk({t, "exc_addr"}, ea, 64'(xa[k]));
  endtask

  task automatic cmp_all();
    ent_t h;
    h = '{default: '0};
    if (q32.size() != 0) h = q32[0];
    cmp_one("d32.", q32.size(), 4, h, 64'(c32), b32.req_ready, b32.mem_valid,
            64'(b32.mem_addr), 64'(b32.mem_be), 64'(b32.mem_wdata), e32_v, 64'(e32_a), 0);
    h = '{default: '0};
    if (q64.size() != 0) h = q64[0];
    cmp_one("d64.", q64.size(), 2, h, 64'(c64), b64.req_ready, b64.mem_valid,
            64'(b64.mem_addr), 64'(b64.mem_be), b64.mem_wdata, e64_v, 64'(e64_a), 1);
  endtask

  task automatic tick();
    cmp_all();
    drive();
    upd(0, 4, 4);
    upd(1, 8, 2);
    @(negedge clk);
  endtask

  task automatic req(int k, bit v, logic [31:0] a, logic [1:0] s, logic [63:0] d, bit mr);
    st[k].v  = v;
    st[k].a  = a;
    st[k].s  = s;
    st[k].d  = d;
    st[k].mr = mr;
  endtask

  task automatic check_zero(string t, logic [63:0] cnt, logic rdy, logic vld, logic [63:0] ad,
                            logic [63:0] be, logic [63:0] wd, logic ev, logic [63:0] ea);
    chk({t, "count"}, cnt, 64'd0);
    chk({t, "req_ready"}, rdy, 64'd1);
    chk({t, "mem_valid"}, vld, 64'd0);
    chk({t, "mem_addr"}, ad, 64'd0);
    chk({t, "mem_be"}, be, 64'd0);
    chk({t, "mem_wdata"}, wd, 64'd0);
    chk({t, "exc_ades"}, ev, 64'd0);
    chk({t, "exc_addr"}, ea, 64'd0);
  endtask

  initial begin
    ent_t e;
    xv[0] = 0; xv[1] = 0; xa[0] = '0; xa[1] = '0;
    req(0, 0, 0, 0, 0, 0); req(1, 0, 0, 0, 0, 0); fl = 0;
    drive();
    reset_n = 1'b1;

    // Hand-computed anchors for the model itself.
    e = entry_of(4, 32'h2002, 2'd1, 64'hFFFF1234);
    chk("model_sh_be", 64'(e.be), 64'h0C);
    chk("model_sh_wd", e.wd, 64'h12340000);
    e = entry_of(8, 32'h0C, 2'd2, 64'hCAFEF00D);
    chk("model_sw64_wd", e.wd, 64'hCAFEF00D_00000000);
    chk("model_sd32_illegal", 64'(legal_of(4, 32'h0, 2'd3)), 64'd0);

    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("rst32.", 64'(c32), b32.req_ready, b32.mem_valid, 64'(b32.mem_addr),
               64'(b32.mem_be), 64'(b32.mem_wdata), e32_v, 64'(e32_a));
    check_zero("rst64.", 64'(c64), b64.req_ready, b64.mem_valid, 64'(b64.mem_addr),
               64'(b64.mem_be), b64.mem_wdata, e64_v, 64'(e64_a));
    reset_n = 1'b1;

    // Byte store to the top lane.
    req(0, 1, 32'h1003, 2'd0, 64'hAB, 1); tick();
    chk("sb_vld", 64'(b32.mem_valid), 64'd1);
    chk("sb_addr", 64'(b32.mem_addr), 64'h1000);
    chk("sb_be", 64'(b32.mem_be), 64'h8);
    chk("sb_wd", 64'(b32.mem_wdata), 64'hAB000000);
    req(0, 0, 0, 0, 0, 1); tick();
    chk("sb_cnt_after_pop", 64'(c32), 64'd0);

    // Halfword aligned, then misaligned.
    req(0, 1, 32'h2002, 2'd1, 64'hFFFF1234, 1); tick();
    chk("sh_be", 64'(b32.mem_be), 64'hC);
    chk("sh_wd", 64'(b32.mem_wdata), 64'h12340000);
    req(0, 1, 32'h2001, 2'd1, 64'hFFFF1234, 1); tick();
    chk("sh_mis_exc", 64'(e32_v), 64'd1);
    chk("sh_mis_addr", 64'(e32_a), 64'h2001);
    chk("sh_mis_cnt", 64'(c32), 64'd0);
    chk("sh_mis_vld", 64'(b32.mem_valid), 64'd0);
    req(0, 0, 0, 0, 0, 1); tick();
    chk("exc_pulse_end", 64'(e32_v), 64'd0);
    chk("exc_addr_hold", 64'(e32_a), 64'h2001);

    // Fill to full, hold a fifth, then drain with wrap.
    for (int i = 0; i < 4; i++) begin
      req(0, 1, 32'h10 + 32'(4 * i), 2'd2, 64'(32'hA0 + i), 0); tick();
    end
    chk("full_cnt", 64'(c32), 64'd4);
    chk("full_rdy", 64'(b32.req_ready), 64'd0);
    req(0, 1, 32'h20, 2'd2, 64'h55, 0); tick();
    chk("held_cnt", 64'(c32), 64'd4);
    chk("held_head", 64'(b32.mem_addr), 64'h10);
    req(0, 1, 32'h20, 2'd2, 64'h55, 1); tick();
    chk("full_pop_cnt", 64'(c32), 64'd3);
    chk("full_pop_head", 64'(b32.mem_addr), 64'h14);
    tick();
    chk("push_pop_cnt", 64'(c32), 64'd3);
    chk("push_pop_head", 64'(b32.mem_addr), 64'h18);
    req(0, 0, 0, 0, 0, 1); tick();
    chk("drain_head3", 64'(b32.mem_addr), 64'h1C);
    tick();
    chk("drain_head5", 64'(b32.mem_addr), 64'h20);
    chk("drain_wd5", 64'(b32.mem_wdata), 64'h55);
    tick();
    chk("drain_empty", 64'(c32), 64'd0);

    // 64-bit lanes.
    req(0, 0, 0, 0, 0, 0);
    req(1, 1, 32'h08, 2'd3, 64'h1122334455667788, 0); tick();
    chk("sd_be", 64'(b64.mem_be), 64'hFF);
    chk("sd_wd", b64.mem_wdata, 64'h1122334455667788);
    chk("sd_addr", 64'(b64.mem_addr), 64'h08);
    req(1, 1, 32'h0C, 2'd2, 64'hCAFEF00D, 1); tick();
    chk("sw64_be", 64'(b64.mem_be), 64'hF0);
    chk("sw64_wd", b64.mem_wdata, 64'hCAFEF00D_00000000);
    chk("sw64_addr", 64'(b64.mem_addr), 64'h08);
    req(1, 0, 0, 0, 0, 1); tick();
    chk("sw64_drained", 64'(c64), 64'd0);

    // Doubleword on a 32-bit bus.
    req(1, 0, 0, 0, 0, 0);
    req(0, 1, 32'h0, 2'd3, 64'h1, 1); tick();
    chk("sd32_exc", 64'(e32_v), 64'd1);
    chk("sd32_cnt", 64'(c32), 64'd0);

    // Flush beats a simultaneous push.
    for (int i = 0; i < 3; i++) begin
      req(0, 1, 32'h30 + 32'(4 * i), 2'd2, 64'(i), 0); tick();
    end
    req(0, 1, 32'h40, 2'd2, 64'h9, 0); fl = 1; tick(); fl = 0;
    chk("flush_cnt", 64'(c32), 64'd0);
    chk("flush_vld", 64'(b32.mem_valid), 64'd0);

    for (int c = 0; c < 2000; c++) begin
      for (int k = 0; k < 2; k++) begin
        st[k].v  = ($urandom_range(0, 9) < 7);
        st[k].s  = 2'($urandom_range(0, 3));
        st[k].a  = $urandom & 32'h0000_03FF;
        st[k].d  = {$urandom, $urandom};
        st[k].mr = ($urandom_range(0, 9) < 5);
      end
      fl = ($urandom_range(0, 39) == 0);
      tick();
    end
    fl = 0;

    // Reset between edges while draining.
    req(1, 0, 0, 0, 0, 0);
    req(0, 1, 32'h31, 2'd1, 64'h0, 0); tick();
    for (int i = 0; i < 3; i++) begin
      req(0, 1, 32'h50 + 32'(4 * i), 2'd2, 64'(i + 7), 0); tick();
    end
    req(0, 0, 0, 0, 0, 1); tick();
    #2 reset_n = 1'b0;
    #1;
    check_zero("arst32.", 64'(c32), b32.req_ready, b32.mem_valid, 64'(b32.mem_addr),
               64'(b32.mem_be), 64'(b32.mem_wdata), e32_v, 64'(e32_a));
    check_zero("arst64.", 64'(c64), b64.req_ready, b64.mem_valid, 64'(b64.mem_addr),
               64'(b64.mem_be), b64.mem_wdata, e64_v, 64'(e64_a));
    q32.delete(); q64.delete();
    xv[0] = 0; xv[1] = 0; xa[0] = '0; xa[1] = '0;
    req(0, 0, 0, 0, 0, 1); req(1, 0, 0, 0, 0, 1);
    drive();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) tick();
    cmp_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
